systolic_matmul_engine: RTL
===========================

// Module: systolic_matmul_engine
// PURPOSE
//  Handshaked, parametrised SIZE x SIZE output-stationary systolic matrix multiplier: C = A*B, or C += A*B.
//  Captures both operand matrices in one transfer and generates the diagonal operand skew internally.
//  Runs a SIZE x SIZE MAC array, then holds C until the consumer accepts it.
//  Sits between an operand loader and a result sink; accumulate mode supports tiled products of larger matrices.
// PARAMETERS
//  SIZE    3   matrix order N (>=2)
//  DATA_W  4   operand element width
//  ACC_W   16  accumulator/result element width (>= 2*DATA_W)
//  SIGNED  0   1: operands two's complement, sign-extended; 0: unsigned, zero-extended
// PORTS
//  clock      in   1                  rising-edge clock
//  reset      in   1                  synchronous, active-high reset
//  in_valid   in   1                  operand transfer offered
//  in_ready   out  1                  engine can accept operands (IDLE only)
//  acc_en     in   1                  sampled with operands: 1 = C += A*B, 0 = C = A*B
//  a_flat     in   SIZE*SIZE*DATA_W   A[r][c] at bits (r*SIZE+c)*DATA_W +: DATA_W
//  b_flat     in   SIZE*SIZE*DATA_W   B, same layout
//  out_valid  out  1                  C valid and stable
//  out_ready  in   1                  consumer accepts C
//  c_flat     out  SIZE*SIZE*ACC_W    C[r][c] at bits (r*SIZE+c)*ACC_W +: ACC_W
//  busy       out  1                  high in RUN
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; busy=0; all accumulators, and therefore c_flat, =0; skew pipes=0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready, at that edge (E0):
//   - latch A, B and acc_en;
//   - clear accumulators if acc_en=0, keep them if acc_en=1;
//   - cnt=0 -> RUN.
//  RUN: in_ready=0, busy=1. Step k=cnt (0..3*SIZE-3).
//   - PE(i,j) adds A[i][t]*B[t][j] for t=k-i-j if 0<=t<SIZE; otherwise it adds 0.
//   - A values flow right and B values flow down through per-PE registers; row i / column j are fed with a delay of i / j.
//   - cnt++; on the edge ending step 3*SIZE-3 -> DONE.
//  DONE: out_valid=1, busy=0. c_flat is stable while out_valid=1.
//   - out_valid&&out_ready -> IDLE; accumulators are retained for a later acc_en=1 pass.
//  Latency: out_valid rises exactly 3*SIZE-2 clocks after E0 (7 for SIZE=3), independent of data.
//  Throughput: 3*SIZE operations per result with an immediate out_ready; no overlap of operand load and drain.
//  Arithmetic:
//   - product is 2*DATA_W bits, sign- or zero-extended to ACC_W;
//   - additions wrap modulo 2^ACC_W; no saturation, no flag.
//  in_valid while in RUN/DONE: ignored and not captured; the source must hold it until in_ready.
//  out_ready while out_valid=0: ignored.
//  Operand inputs change during RUN: no effect, because operands are latched.
//  Reset asserted in any state, including mid-RUN: full reset values on the next edge; the partial result is discarded.
//  acc_en=1 on the first transfer after reset: accumulates onto 0, so it is equivalent to acc_en=0.
//  c_flat in IDLE/RUN: reflects the live accumulators; it is meaningful only while out_valid=1.
// TESTING
//  1. SIZE=3, A=identity, B[r][c]=r*3+c, acc_en=0 -> C==B; out_valid 7 clocks after E0.
//  2. SIZE=3, SIGNED=0, all A,B=15 -> every C element = 675 (0x02A3).
//  3. SIGNED=1, all A,B=-8 (4'h8) -> every C element = 192. Then all A=-8, B=7 -> every element = -168 (16'hFF58).
//  4. Accumulate chain:
//   - pass 1: test 2 operands, acc_en=0;
//   - pass 2: same operands, acc_en=1;
//   -> every element = 1350.
//  5. Backpressure: hold out_ready=0 for 5 clocks in DONE and pulse in_valid with new data
//   -> c_flat unchanged, in_ready=0, no capture; out_ready=1 -> IDLE next clock.
//  6. Reset at step 3 of RUN -> next clock IDLE, c_flat=0, out_valid=0. A fresh transfer then produces the correct C.

Source files
------------

// File: rtl/systolic_matmul_engine.sv
// Output-stationary SIZE x SIZE systolic matrix multiplier with a valid/ready operand and result
// handshake. Operands are latched once, and the diagonal skew is generated from the step counter.
module systolic_matmul_engine #(
    parameter int SIZE   = 3,
    parameter int DATA_W = 4,
    parameter int ACC_W  = 16,
    parameter int SIGNED = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         acc_en,
    input  logic [SIZE*SIZE*DATA_W-1:0]  a_flat,
    input  logic [SIZE*SIZE*DATA_W-1:0]  b_flat,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SIZE*SIZE*ACC_W-1:0]   c_flat,
    output logic                         busy
);

    localparam int LAST  = 3 * SIZE - 3;
    localparam int CNT_W = $clog2(3 * SIZE);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic start;

    logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] a_q, b_q;
    logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] a_in, b_in;
    logic [SIZE-1:0][SIZE-2:0][DATA_W-1:0] a_pipe;
    logic [SIZE-2:0][SIZE-1:0][DATA_W-1:0] b_pipe;
    logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0]  acc_q, acc_sum;
    logic [SIZE-1:0][DATA_W-1:0]           feed_a, feed_b;

    function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v);
        if (SIGNED != 0) begin
            return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
        end
        return {{(ACC_W-DATA_W){1'b0}}, v};
    endfunction

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StRun;
            end
            StRun: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(LAST)) state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign start = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Edge feeds: row i carries A[i][k-i] and column j carries B[k-j][j] at step k.
    always_comb begin
        feed_a = '0;
        feed_b = '0;
        for (int i = 0; i < SIZE; i++) begin
            for (int t = 0; t < SIZE; t++) begin
                if (int'(cnt_q) == i + t) begin
                    feed_a[i] = a_q[i][t];
                    feed_b[i] = b_q[t][i];
                end
            end
        end
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_row
        for (genvar j = 0; j < SIZE; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_in[i][j] = feed_a[i];
            end else begin : g_a_pipe
                assign a_in[i][j] = a_pipe[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in[i][j] = feed_b[j];
            end else begin : g_b_pipe
                assign b_in[i][j] = b_pipe[i-1][j];
            end
            assign acc_sum[i][j] = acc_q[i][j] + ext(a_in[i][j]) * ext(b_in[i][j]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            a_pipe <= '0;
            b_pipe <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            a_q    <= a_flat;
            b_q    <= b_flat;
            a_pipe <= '0;
            b_pipe <= '0;
            cnt_q  <= '0;
            if (!acc_en) acc_q <= '0;
        end else if (state_q == StRun) begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_sum;
            for (int i = 0; i < SIZE; i++) begin
                a_pipe[i] <= a_in[i][SIZE-2:0];
            end
            b_pipe <= b_in[SIZE-2:0];
        end
    end

    assign c_flat = acc_q;

endmodule
